outbound_unloader: RTL

Drains the outbound buffer of the PE register files and streams it to the network side as phits. It is the read-side counterpart of the runtime table/inbound loader. The loader writes phits into tables and the inbound half of each RF. This block reads result entries from the outbound half of the RF and emits them on a valid/ready stream with backpressure. It sits between the RF read port arbitration and the stream-out path of the control plane.

---
 rtl/outbound_unloader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/outbound_unloader.sv
// outbound_unloader: drains the outbound half of the PE register file and
// streams each entry as one phit on a valid/ready interface. Reads are
// issued against a credit (FIFO occupancy + reads in flight) so the skid
// FIFO can always absorb every returning word, whatever the backpressure.
module outbound_unloader #(
    parameter int phit_size     = 512,
    parameter int dwidth_RFadd  = 10,
    parameter int base_outbound = 512,
    parameter int rd_latency    = 1,
    parameter int fifo_depth    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_unloader,
    input  logic [dwidth_RFadd-1:0] num_entry_outbound,
    output logic                    rd_en_RF,
    output logic [dwidth_RFadd-1:0] rd_add_RF,
    input  logic [phit_size-1:0]    rd_data_RF,
    output logic [phit_size-1:0]    stream_out_data,
    output logic                    stream_out_valid,
    input  logic                    stream_out_ready,
    output logic                    stream_out_last,
    output logic                    busy,
    output logic                    done_unloader
);

    localparam int AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CW = AW + 1;
    localparam logic [dwidth_RFadd-1:0] BASE_A = dwidth_RFadd'(base_outbound);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [dwidth_RFadd-1:0] count_q;
    logic [dwidth_RFadd-1:0] cnt_m1;
    logic [dwidth_RFadd-1:0] issued;
    logic [dwidth_RFadd-1:0] sent;
    logic [CW-1:0]           occ;
    logic [CW-1:0]           inflight;
    logic [CW:0]             credit_used;
    logic [rd_latency-1:0]   vld_pipe;
    logic [phit_size-1:0]    mem [fifo_depth];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic                    issue, fifo_wr, pop, start_ok;

    assign cnt_m1      = count_q - dwidth_RFadd'(1);
    assign credit_used = {1'b0, occ} + {1'b0, inflight};
    assign start_ok    = (state == IDLE) && start_unloader;

    // Read issue is gated by credit so a returning word always has a FIFO slot.
    always_comb begin
        issue   = (state == READ) && (credit_used < (CW+1)'(fifo_depth));
        fifo_wr = vld_pipe[rd_latency-1];
        pop     = stream_out_valid && stream_out_ready;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a start seen outside IDLE is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_unloader)
                       state_nxt = (num_entry_outbound != '0) ? READ : DONE;
            READ:  if (issue && (issued == cnt_m1)) state_nxt = DRAIN;
            DRAIN: if (pop && stream_out_last)      state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Drain bookkeeping: latched count, issue and accept counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            issued  <= '0;
            sent    <= '0;
        end else if (start_ok) begin
            count_q <= num_entry_outbound;
            issued  <= '0;
            sent    <= '0;
        end else begin
            if (issue) issued <= issued + dwidth_RFadd'(1);
            if (pop)   sent   <= sent + dwidth_RFadd'(1);
        end
    end

    // Read-return tracking: the issue bit emerges when rd_data_RF is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= issue;
            for (int i = 1; i < rd_latency; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Credit counters: reads in flight and FIFO occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
            occ      <= '0;
        end else begin
            inflight <= inflight + CW'(issue) - CW'(fifo_wr);
            occ      <= occ + CW'(fifo_wr) - CW'(pop);
        end
    end

    // FIFO pointers; write and pop in the same cycle are both honoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // FIFO storage; contents need no reset since the head is masked when empty.
    always_ff @(posedge clk) begin
        if (!rst && fifo_wr) mem[wr_ptr] <= rd_data_RF;
    end

    // Outputs: show-ahead head, address only driven on issue cycles.
    always_comb begin
        rd_en_RF         = issue;
        rd_add_RF        = issue ? (BASE_A + issued) : '0;
        stream_out_valid = (occ != '0);
        stream_out_data  = stream_out_valid ? mem[rd_ptr] : '0;
        stream_out_last  = stream_out_valid && (sent == cnt_m1);
        busy             = (state != IDLE);
        done_unloader    = (state == DONE);
    end

endmodule
